// File: rtl/cd_csr_arb_if.sv
// cd_csr_arb_if: two-master CSR arbitration bus bundle (master side drives requests, slave side is the arbiter)
interface cd_csr_arb_if;
  logic       m0_req, m0_lock, m0_read, m0_write, m0_gnt;
  logic [4:0] m0_address;
  logic [7:0] m0_writedata, m0_readdata;
  logic       m1_req, m1_lock, m1_read, m1_write, m1_gnt;
  logic [4:0] m1_address;
  logic [7:0] m1_writedata, m1_readdata;
  logic [4:0] csr_address;
  logic       csr_read, csr_write;
  logic [7:0] csr_writedata, csr_readdata;
  logic       timeout_pulse;
  modport slave (
    input  m0_req, m0_lock, m0_read, m0_write, m0_address, m0_writedata,
    input  m1_req, m1_lock, m1_read, m1_write, m1_address, m1_writedata,
    input  csr_readdata,
    output m0_gnt, m0_readdata, m1_gnt, m1_readdata,
    output csr_address, csr_read, csr_write, csr_writedata, timeout_pulse
  );
  modport master (
    output m0_req, m0_lock, m0_read, m0_write, m0_address, m0_writedata,
    output m1_req, m1_lock, m1_read, m1_write, m1_address, m1_writedata,
    output csr_readdata,
    input  m0_gnt, m0_readdata, m1_gnt, m1_readdata,
    input  csr_address, csr_read, csr_write, csr_writedata, timeout_pulse
  );
endinterface

// File: rtl/cd_csr_arb.sv
// cd_csr_arb: round-robin two-master CSR bus arbiter with lock and idle timeout
module cd_csr_arb #(
  parameter int TIMEOUT = 255
) (
  input logic        clk,
  input logic        reset,
  cd_csr_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t     state, state_n;
  logic       rr, ex0, ex1, tp, acc, tmo, e0, e1, own0, own1;
  logic [7:0] cnt;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign e0   = bus.m0_req & ~ex0;
  assign e1   = bus.m1_req & ~ex1;
  assign acc  = (own0 & (bus.m0_read | bus.m0_write)) | (own1 & (bus.m1_read | bus.m1_write));
  assign tmo  = (TIMEOUT != 0) && (state != IDLE) && !acc && (cnt == TO_LAST);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (e0 && e1) ? (rr ? OWN1 : OWN0) : e0 ? OWN0 : e1 ? OWN1 : IDLE;
      OWN0:    state_n = (!bus.m0_req || tmo) ? (e1 ? OWN1 : IDLE) : (!bus.m0_lock && e1 && acc) ? OWN1 : OWN0;
      OWN1:    state_n = (!bus.m1_req || tmo) ? (e0 ? OWN0 : IDLE) : (!bus.m1_lock && e0 && acc) ? OWN0 : OWN1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr    <= 1'b0;
      cnt   <= '0;
      tp    <= 1'b0;
      ex0   <= 1'b0;
      ex1   <= 1'b0;
    end else begin
      state <= state_n;
      rr    <= (own0 && state_n != OWN0) ? 1'b1 : (own1 && state_n != OWN1) ? 1'b0 : rr;
      cnt   <= (acc || state_n != state) ? 8'd0 : (state != IDLE && cnt != 8'hff) ? cnt + 8'd1 : cnt;
      tp    <= tmo;
      ex0   <= (tmo & own0) | (ex0 & bus.m0_req);
      ex1   <= (tmo & own1) | (ex1 & bus.m1_req);
    end
  end
  assign bus.m0_gnt        = own0;
  assign bus.m1_gnt        = own1;
  assign bus.csr_address   = own0 ? bus.m0_address : own1 ? bus.m1_address : '0;
  assign bus.csr_writedata = own0 ? bus.m0_writedata : own1 ? bus.m1_writedata : '0;
  assign bus.csr_read      = own0 ? bus.m0_read : own1 ? bus.m1_read : 1'b0;
  assign bus.csr_write     = own0 ? bus.m0_write : own1 ? bus.m1_write : 1'b0;
  assign bus.m0_readdata   = own0 ? bus.csr_readdata : '0;
  assign bus.m1_readdata   = own1 ? bus.csr_readdata : '0;
  assign bus.timeout_pulse = tp;
endmodule

// File: tb/tb_cd_csr_arb.sv
// tb_cd_csr_arb: directed self-checking bench for cd_csr_arb
module tb_cd_csr_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   wcnt = 0;
  cd_csr_arb_if bus ();
  cd_csr_arb #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.csr_readdata = {3'b101, bus.csr_address};
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  function automatic logic [31:0] outs();
    return {bus.m0_gnt, bus.m1_gnt, bus.csr_read, bus.csr_write, bus.csr_address,
            bus.csr_writedata, bus.timeout_pulse};
  endfunction
  initial begin
    {bus.m0_req, bus.m0_lock, bus.m0_read, bus.m0_write} = '0;
    {bus.m1_req, bus.m1_lock, bus.m1_read, bus.m1_write} = '0;
    bus.m0_address = '0; bus.m0_writedata = '0;
    bus.m1_address = '0; bus.m1_writedata = '0;
    nxt();
    nxt();
    mid();
    chk("rst_outs", outs(), 32'h0);
    chk("rst_rdata", {bus.m0_readdata, bus.m1_readdata}, 32'h0);
    nxt();
    reset = 1'b0;
    bus.m0_req = 1; bus.m1_req = 1;
    bus.m0_read = 1; bus.m1_read = 1;
    bus.m0_address = 5'h12; bus.m1_address = 5'h12;
    mid();
    chk("idle_no_gnt", {bus.m0_gnt, bus.m1_gnt, bus.csr_read}, 32'h0);
    nxt();
    mid();
    chk("both_req_m0_first", {bus.m0_gnt, bus.m1_gnt, bus.csr_read, bus.csr_address}, {3'b101, 5'h12});
    chk("m0_rdata", {bus.m0_readdata, bus.m1_readdata}, 32'hB200);
    nxt();
    mid();
    chk("rr_m1_second", {bus.m0_gnt, bus.m1_gnt, bus.csr_read, bus.csr_address}, {3'b011, 5'h12});
    chk("m1_rdata", {bus.m0_readdata, bus.m1_readdata}, 32'h00B2);
    nxt();
    mid();
    chk("rr_m0_third", {bus.m0_gnt, bus.m1_gnt}, 32'h2);
    {bus.m0_req, bus.m1_req, bus.m0_read, bus.m1_read} = '0;
    nxt();
    mid();
    chk("release_idle", {bus.m0_gnt, bus.m1_gnt}, 32'h0);
    bus.m1_req = 1;
    nxt();
    mid();
    chk("single_m1", {bus.m0_gnt, bus.m1_gnt}, 32'h1);
    bus.m0_req = 1;
    nxt();
    mid();
    chk("no_access_keeps_m1", {bus.m0_gnt, bus.m1_gnt}, 32'h1);
    bus.m1_req = 0;
    nxt();
    mid();
    chk("handover_no_bubble", {bus.m0_gnt, bus.m1_gnt}, 32'h2);
    bus.m0_req = 0;
    nxt();
    bus.m0_req = 1; bus.m0_lock = 1;
    nxt();
    bus.m1_req = 1; bus.m1_write = 1; bus.m1_address = 5'h17; bus.m1_writedata = 8'hEE;
    bus.m0_write = 1; bus.m0_address = 5'h15;
    for (int i = 0; i < 10; i++) begin
      bus.m0_writedata = 8'(i + 1);
      mid();
      chk("lock_burst", outs(), {4'b1001, 5'h15, 8'(i + 1), 1'b0});
      if (bus.csr_write && bus.csr_address == 5'h15) wcnt++;
      if (i == 9) {bus.m0_req, bus.m0_lock, bus.m0_write} = '0;
      nxt();
    end
    mid();
    chk("burst_count", wcnt, 10);
    chk("m1_after_drop", outs(), {4'b0101, 5'h17, 8'hEE, 1'b0});
    bus.m1_req = 0;
    nxt();
    mid();
    chk("nonowner_write_blocked", outs(), 32'h0);
    bus.m1_write = 0;
    bus.m0_req = 1; bus.m0_lock = 1;
    nxt();
    bus.m1_req = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("lock_idle_hold", {bus.m0_gnt, bus.m1_gnt, bus.timeout_pulse}, 32'h4);
      nxt();
    end
    mid();
    chk("timeout_to_m1", {bus.m0_gnt, bus.m1_gnt, bus.timeout_pulse}, 32'h3);
    bus.m1_req = 0;
    nxt();
    mid();
    chk("m0_excluded_a", {bus.m0_gnt, bus.m1_gnt, bus.timeout_pulse}, 32'h0);
    nxt();
    mid();
    chk("m0_excluded_b", {bus.m0_gnt, bus.m1_gnt}, 32'h0);
    bus.m0_req = 0;
    nxt();
    bus.m0_req = 1;
    nxt();
    mid();
    chk("m0_regrant", {bus.m0_gnt, bus.m1_gnt}, 32'h2);
    bus.m0_write = 1; bus.m0_address = 5'h15; bus.m0_writedata = 8'h5A;
    nxt();
    mid();
    chk("burst_write", outs(), {4'b1001, 5'h15, 8'h5A, 1'b0});
    reset = 1;
    nxt();
    mid();
    chk("reset_mid_burst", outs(), 32'h0);
    chk("reset_rdata", {bus.m0_readdata, bus.m1_readdata}, 32'h0);
    reset = 0;
    bus.m0_read = 1;
    nxt();
    mid();
    chk("rd_wr_together", outs(), {4'b1011, 5'h15, 8'h5A, 1'b0});
    chk("rd_wr_rdata", {bus.m0_readdata, bus.m1_readdata}, 32'hB500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cd_csr_arb.md
CD_CSR_ARB -- requirements
Module: cd_csr_arb

Interface
REQ-001 Parameter: TIMEOUT, default 255, owner-idle cycles before forced release; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_req, m1_req  input  1 each  master requests CSR bus ownership.
REQ-005 m0_lock, m1_lock  input  1 each  owner keeps the bus across accesses (burst, e.g. TX frame fill).
REQ-006 m0_address, m1_address  input  5 each  CSR address.
REQ-007 m0_read, m0_write, m1_read, m1_write  input  1 each  access strobes.
REQ-008 m0_writedata, m1_writedata  input  8 each  write data.
REQ-009 m0_readdata, m1_readdata  output  8 each  read data returned to the master.
REQ-010 m0_gnt, m1_gnt  output  1 each  registered grant; at most one is high.
REQ-011 csr_address  output  5  to CSR slave.
REQ-012 csr_read, csr_write  output  1 each  to CSR slave.
REQ-013 csr_writedata  output  8  to CSR slave.
REQ-014 csr_readdata  input  8  combinational read data from CSR slave.
REQ-015 timeout_pulse  output  1  one-cycle pulse on forced release.

Function
REQ-016 States: IDLE, OWN0, OWN1; mX_gnt = (state == OWNX), registered.
REQ-017 Slave bus muxed combinationally from the owner; csr_read = owner_read & gnt, csr_write = owner_write & gnt; in IDLE csr_address, csr_writedata = 0 and strobes = 0.
REQ-018 An access occurs in any cycle where the owner has gnt high and read or write high; strobes from a non-owner never reach the slave.
REQ-019 Owner's mX_readdata = csr_readdata same cycle; non-owner's readdata = 0.
REQ-020 Owner asserting read and write together: both forwarded unchanged.
REQ-021 IDLE: one request -> grant that master next cycle; both -> grant the rr_ptr-preferred master; none -> stay.
REQ-022 rr_ptr: 1 bit, 0 = m0 preferred; on every exit from OWNX, rr_ptr points to the other master.
REQ-023 OWNX, reqX low: if the other req is high -> OWN(other) next cycle (no IDLE bubble), else -> IDLE.
REQ-024 OWNX, reqX high, lockX low, other req high, access this cycle -> OWN(other) next cycle (one access per grant under contention).
REQ-025 OWNX, reqX high, lockX high -> stay regardless of the other request; lock is sampled every cycle.
REQ-026 Idle counter: 8 bit; cleared on any access and on any state change; increments each OWNX cycle without an access; saturates.
REQ-027 TIMEOUT != 0 and counter == TIMEOUT-1 in a cycle without an access -> forced exit per REQ-023 rules as if reqX were low; timeout_pulse = 1 in the following cycle.
REQ-028 A master whose grant was forced off must drop req for at least one cycle before it is eligible again.
REQ-029 Grant latency from IDLE: req at edge N -> gnt high after edge N+1.

Reset
REQ-030 While reset is high at a clock edge: state = IDLE, rr_ptr = 0, counter = 0, timeout_pulse = 0, both gnt = 0, all csr_* outputs = 0, readdata = 0.
REQ-031 Reset mid-burst: gnt drops after the reset edge; the in-flight strobe is not extended.

Verification
REQ-032 Out of reset, both req high same cycle -> m0_gnt = 1 next cycle; m1 granted after m0's first access.
REQ-033 m0 holds lock, writes 10 bytes to 0x15 while m1 requests -> exactly 10 csr_write pulses at 0x15, no m1 access interleaved; m1_gnt = 1 the cycle after m0_req drops.
REQ-034 Unlocked contention, both masters read 0x12 repeatedly -> grants alternate m0, m1, m0 with one read each; m1 read of 0x12 never while m0_gnt.
REQ-035 TIMEOUT = 4, m0 owns with lock but no access -> forced release after 4 idle cycles, timeout_pulse one cycle, m1 granted if requesting, m0 excluded until req toggles.
REQ-036 m1 asserts m1_write to 0x17 without gnt -> csr_write stays 0; reset asserted during m0 burst -> IDLE, all outputs 0 next cycle.
